// File: rtl/cic_tx_pkg.sv
// rtl/cic_tx_pkg.sv - shared widths, bit-select offset and ratio clamp for the TX CIC interpolator
package cic_tx_pkg;

  typedef enum logic {STAGE_COMB, STAGE_INTEG} stage_mode_e;

  function automatic int comb_w(input int in_w, input int n);
    return in_w + n;
  endfunction

  function automatic int acc_w(input int in_w, input int n, input int max_k);
    return in_w + n * max_k;
  endfunction

  // Integrator growth is R**(N-1) after zero-stuffing, so unity gain drops (N-1)*k bits.
  function automatic int out_offset(input int n, input int k);
    return (n - 1) * k;
  endfunction

  function automatic int clamp_k(input int k, input int max_k);
    return (k > max_k) ? max_k : k;
  endfunction

endpackage

// File: rtl/cic_interp_stage.sv
// rtl/cic_interp_stage.sv - one CIC comb (D=1) or integrator stage, advancing only when enabled
module cic_interp_stage
  import cic_tx_pkg::*;
#(
  parameter stage_mode_e MODE  = STAGE_COMB,
  parameter int          WIDTH = 21
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] out_data
);

  logic signed [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (enable) begin
      state_d = (MODE == STAGE_COMB) ? in_data : state_q + in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Comb output is combinational from the live input; integrator output is its register.
  assign out_data = (MODE == STAGE_COMB) ? in_data - state_q : state_q;

endmodule

// File: rtl/cic_interp_var.sv
// rtl/cic_interp_var.sv - variable 2**k interpolating CIC (D=1) with request/hold input and unity-gain output
module cic_interp_var
  import cic_tx_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 18,
  parameter int MAX_LOG2_R = 4,
  parameter int LW         = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [LW-1:0]               interp_log2,
  input  logic                        out_tick,
  output logic                        in_req,
  input  logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        underrun,
  output logic                        overrun
);

  localparam int COMB_W = comb_w(IN_WIDTH, STAGES);
  localparam int ACC_W  = acc_w(IN_WIDTH, STAGES, MAX_LOG2_R);
  localparam int PW     = (MAX_LOG2_R > 0) ? MAX_LOG2_R : 1;
  localparam int SW     = $clog2(ACC_W);

  logic [PW-1:0]                 phase_q, phase_d;
  logic [LW-1:0]                 k_q, k_d;
  logic signed [IN_WIDTH-1:0]    hold_q, hold_d;
  logic                          hold_valid_q, hold_valid_d;
  logic                          started_q, started_d;
  logic                          in_req_q, in_req_d;
  logic                          out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          underrun_q, underrun_d;
  logic                          overrun_q, overrun_d;

  logic [LW-1:0]                 k_eff;
  logic [PW-1:0]                 phase_last;
  logic                          phase0_tick;
  logic                          wrap_tick;
  logic [SW-1:0]                 sel_top;
  logic signed [IN_WIDTH-1:0]    sample;
  logic signed [COMB_W-1:0]      comb_out;
  logic signed [ACC_W-1:0]       acc_last;

  wire [STAGES:0][COMB_W-1:0]    comb_c;
  wire [STAGES:0][ACC_W-1:0]     integ_i;

  assign comb_c[0]  = COMB_W'(sample);
  assign comb_out   = comb_c[STAGES];
  assign integ_i[0] = phase0_tick ? ACC_W'(comb_out) : '0;
  assign acc_last   = integ_i[STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cic_interp_stage #(.MODE(STAGE_COMB), .WIDTH(COMB_W)) u_comb (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (phase0_tick),
      .in_data  (comb_c[g]),
      .out_data (comb_c[g+1])
    );
    cic_interp_stage #(.MODE(STAGE_INTEG), .WIDTH(ACC_W)) u_integ (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (out_tick),
      .in_data  (integ_i[g]),
      .out_data (integ_i[g+1])
    );
  end

  always_comb begin
    // A new ratio is only picked up at phase 0, so it governs a whole period.
    k_eff       = (phase_q == '0) ? LW'(clamp_k(int'(interp_log2), MAX_LOG2_R)) : k_q;
    phase_last  = PW'((32'd1 << k_eff) - 32'd1);
    phase0_tick = out_tick && (phase_q == '0);
    wrap_tick   = out_tick && (phase_q == phase_last);
    sel_top     = SW'(out_offset(STAGES, int'(k_eff)) + IN_WIDTH - 1);

    if (in_strobe) begin
      sample = in_data;
    end else if (hold_valid_q) begin
      sample = hold_q;
    end else begin
      sample = '0;
    end

    phase_d = phase_q;
    if (out_tick) begin
      phase_d = wrap_tick ? '0 : phase_q + PW'(1);
    end
    k_d    = phase0_tick ? k_eff : k_q;
    hold_d = in_strobe ? in_data : hold_q;

    hold_valid_d = hold_valid_q;
    if (phase0_tick) begin
      hold_valid_d = 1'b0;
    end else if (in_strobe) begin
      hold_valid_d = 1'b1;
    end

    started_d    = 1'b1;
    in_req_d     = wrap_tick || !started_q;
    out_strobe_d = out_tick;
    out_data_d   = out_tick ? acc_last[sel_top -: OUT_WIDTH] : out_data_q;
    underrun_d   = underrun_q || (phase0_tick && !in_strobe && !hold_valid_q);
    overrun_d    = overrun_q || (in_strobe && hold_valid_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= '0;
      k_q          <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      started_q    <= 1'b0;
      in_req_q     <= 1'b0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      k_q          <= k_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      started_q    <= started_d;
      in_req_q     <= in_req_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign in_req     = in_req_q;
  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_interp_var.sv
// tb/tb_cic_interp_var.sv - randomized and directed bench against a convolution model of the CIC interpolator
module tb_cic_interp_var;

  localparam int N  = 3;
  localparam int IW = 18;
  localparam int M_IMPULSE = 0, M_DC = 1, M_RAMP = 2, M_RANDOM = 3, M_BYPASS = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b1;
  logic [2:0]           interp_log2 = 3'd0;
  logic                 out_tick = 1'b0;
  logic                 in_strobe = 1'b0;
  logic signed [IW-1:0] in_data = '0;
  logic                 in_req, out_strobe, underrun, overrun;
  logic signed [IW-1:0] out_data;

  cic_interp_var dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .interp_log2 (interp_log2),
    .out_tick    (out_tick),
    .in_req      (in_req),
    .in_strobe   (in_strobe),
    .in_data     (in_data),
    .out_strobe  (out_strobe),
    .out_data    (out_data),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  int      kk, rr, tick_n, phase, samp_i;
  longint  dc_val;
  longint  h[$];
  longint  xs[$];
  logic signed [IW-1:0] strobe_log[$];
  bit      pend_valid, started, check_en = 1'b0;
  logic signed [IW-1:0] pend;
  logic    exp_in_req, exp_out_strobe, exp_underrun, exp_overrun;
  logic signed [IW-1:0] exp_out_data;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Impulse response of N cascaded length-R boxcars.
  function automatic void build_h();
    longint t[$];
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      t.delete();
      for (int i = 0; i < h.size() + rr - 1; i++) t.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < rr; j++) t[i+j] += h[i];
      h = t;
    end
  endfunction

  function automatic longint y_at(input int t);
    longint acc = 0;
    if (t < 0) return 0;
    for (int j = 0; j < xs.size(); j++) begin
      int d = t - j * rr;
      if (d >= 0 && d < h.size()) acc += h[d] * xs[j];
    end
    return acc >>> ((N - 1) * kk);
  endfunction

  function automatic void model_reset(input int k);
    kk = (k > 4) ? 4 : k;
    rr = 1 << kk;
    build_h();
    xs.delete();
    strobe_log.delete();
    tick_n = 0; phase = 0; samp_i = 0;
    pend_valid = 1'b0; pend = '0; started = 1'b0;
    exp_in_req = 1'b0; exp_out_strobe = 1'b0; exp_underrun = 1'b0; exp_overrun = 1'b0;
    exp_out_data = '0;
  endfunction

  function automatic void model_step(input bit tk, input bit st, input logic signed [IW-1:0] d);
    exp_out_strobe = tk;
    exp_in_req = !started || (tk && phase == rr - 1);
    started = 1'b1;
    if (st && pend_valid) exp_overrun = 1'b1;
    if (tk && phase == 0) begin
      if (st) xs.push_back(longint'(d));
      else if (pend_valid) xs.push_back(longint'(pend));
      else begin
        xs.push_back(0);
        exp_underrun = 1'b1;
      end
      pend_valid = 1'b0;
    end else if (st) begin
      pend = d;
      pend_valid = 1'b1;
    end
    if (tk) begin
      exp_out_data = IW'(y_at(tick_n - N));
      tick_n++;
      phase = (phase + 1) % rr;
    end
  endfunction

  function automatic logic signed [IW-1:0] next_sample(input int mode);
    logic signed [IW-1:0] v;
    case (mode)
      M_IMPULSE:    v = (samp_i == 0) ? 18'sd4096 : 18'sd0;
      M_DC, M_BYPASS: v = IW'(dc_val);
      M_RAMP:       v = IW'(samp_i);
      default:      v = IW'($urandom);
    endcase
    samp_i++;
    return v;
  endfunction

  always @(negedge clock) begin
    if (check_en) begin
      check("in_req", in_req, exp_in_req);
      check("out_strobe", out_strobe, exp_out_strobe);
      check("out_data", out_data, exp_out_data);
      check("underrun", underrun, exp_underrun);
      check("overrun", overrun, exp_overrun);
      if (out_strobe) strobe_log.push_back(out_data);
    end
  end

  task automatic cycle(input bit tk, input bit st, input logic signed [IW-1:0] d);
    out_tick = tk;
    in_strobe = st;
    in_data = d;
    @(posedge clock);
    model_step(tk, st, d);
    @(negedge clock);
  endtask

  // Source answers each in_req with one strobe (two for dbl_n, none for skip_n).
  task automatic run(input int ncyc, input int mode, input int skip_n, input int dbl_n, output int reqs);
    int want_n;
    bit tk, st;
    logic signed [IW-1:0] d;
    reqs = 0;
    want_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      tk = ((c % 4) == 3);
      if (in_req) begin
        if (reqs != skip_n) want_n = (reqs == dbl_n) ? 2 : 1;
        reqs++;
      end
      st = 1'b0;
      d = '0;
      if (want_n > 0 && (mode != M_BYPASS || (tk && phase == 0))) begin
        st = 1'b1;
        d = next_sample(mode);
        want_n--;
      end
      cycle(tk, st, d);
    end
    out_tick = 1'b0;
    in_strobe = 1'b0;
  endtask

  task automatic apply_reset(input logic [2:0] k);
    #2;
    reset_n = 1'b0;
    out_tick = 1'b0;
    in_strobe = 1'b0;
    in_data = '0;
    model_reset(int'(k));
    check_en = 1'b1;
    #1;
    check("rst_in_req", in_req, 0);
    check("rst_out_strobe", out_strobe, 0);
    check("rst_out_data", out_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clock);
    @(negedge clock);
    interp_log2 = k;
    reset_n = 1'b1;
  endtask

  initial begin
    int reqs;
    @(negedge clock);

    apply_reset(3'd1);
    run(162, M_IMPULSE, -1, -1, reqs);
    check("imp_len", strobe_log.size() >= 8, 1);
    check("imp_t2", strobe_log[2], 0);
    check("imp_t3", strobe_log[3], 1024);
    check("imp_t4", strobe_log[4], 3072);
    check("imp_t5", strobe_log[5], 3072);
    check("imp_t6", strobe_log[6], 1024);
    check("imp_t7", strobe_log[7], 0);

    dc_val = -5000;
    apply_reset(3'd4);
    run(258, M_DC, -1, -1, reqs);
    check("dc_value", out_data, -5000);
    check("dc_req_count", reqs, 5);

    dc_val = 1234;
    apply_reset(3'd7);
    run(258, M_DC, -1, -1, reqs);
    check("clamp_value", out_data, 1234);
    check("clamp_req_count", reqs, 5);

    apply_reset(3'd0);
    run(82, M_RAMP, -1, -1, reqs);
    check("ramp_last", out_data, 16);
    check("ramp_req_count", reqs, 21);

    apply_reset(3'd1);
    run(242, M_RANDOM, 3, 6, reqs);
    check("underrun_set", underrun, 1);
    check("overrun_set", overrun, 1);

    dc_val = 777;
    apply_reset(3'd2);
    run(162, M_BYPASS, -1, -1, reqs);
    check("bypass_no_underrun", underrun, 0);
    check("bypass_value", out_data, 777);

    apply_reset(3'd3);
    run(100, M_RANDOM, -1, -1, reqs);
    apply_reset(3'd3);
    cycle(1'b0, 1'b0, '0);
    check("req_after_release", in_req, 1);
    run(120, M_RANDOM, -1, -1, reqs);

    apply_reset(3'd4);
    run(400, M_RANDOM, -1, -1, reqs);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
